// File: rtl/index_vector_packer.sv
// Packs a stream of 1-based bit indices into a WIDTH-bit vector with popcount, hi and lo indices.
// Optional: define INDEX_VECTOR_PACKER_DUP_ERR_EN to flag duplicate indices in o_vec_err.
module index_vector_packer #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned IW = $clog2(WIDTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_idx_valid,
  output logic             o_idx_ready,
  input  logic [IW-1:0]    i_idx,
  input  logic             i_idx_last,
  output logic             o_vec_valid,
  input  logic             i_vec_ready,
  output logic [WIDTH-1:0] o_vec,
  output logic [IW-1:0]    o_vec_count,
  output logic [IW-1:0]    o_vec_hi,
  output logic [IW-1:0]    o_vec_lo,
  output logic             o_vec_err
);

  localparam logic [0:0]    StAccum = 1'b0;
  localparam logic [0:0]    StHold  = 1'b1;
  localparam logic [IW-1:0] IdxMax  = IW'(WIDTH);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] vec_q, vec_d;
  logic [IW-1:0]    count_q, count_d;
  logic [IW-1:0]    hi_q, hi_d;
  logic [IW-1:0]    lo_q, lo_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] idx_mask;
  logic             idx_dup;
  logic             idx_new;
  logic             idx_oor;
  logic             beat_err;
  logic             beat_acc;

  // One-hot decode of the index; index 0 and out-of-range indices decode to all zeros.
  always_comb begin
    idx_mask = '0;
    for (int k = 0; k < WIDTH; k++) begin
      idx_mask[k] = (i_idx == IW'(k + 1));
    end
  end

  assign idx_dup = |(idx_mask & vec_q);
  assign idx_new = (|idx_mask) & ~idx_dup;
  assign idx_oor = (i_idx > IdxMax);

`ifdef INDEX_VECTOR_PACKER_DUP_ERR_EN
  assign beat_err = idx_oor | idx_dup;
`else
  assign beat_err = idx_oor;
`endif

  assign o_idx_ready = (state_q == StAccum) & ~i_rst;
  assign o_vec_valid = (state_q == StHold);
  assign beat_acc    = i_idx_valid & o_idx_ready;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    err_d   = err_q;
    case (state_q)
      StAccum: begin
        if (beat_acc) begin
          if (idx_new) begin
            vec_d   = vec_q | idx_mask;
            count_d = count_q + IW'(1);
            if (i_idx > hi_q) begin
              hi_d = i_idx;
            end
            if ((lo_q == '0) || (i_idx < lo_q)) begin
              lo_d = i_idx;
            end
          end
          if (beat_err) begin
            err_d = 1'b1;
          end
          if (i_idx_last) begin
            state_d = StHold;
          end
        end
      end
      StHold: begin
        // Clearing here leaves the outputs reading zero once back in ACCUM.
        if (i_vec_ready) begin
          state_d = StAccum;
          vec_d   = '0;
          count_d = '0;
          hi_d    = '0;
          lo_d    = '0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = StAccum;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StAccum;
      vec_q   <= '0;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      err_q   <= err_d;
    end
  end

  assign o_vec       = vec_q;
  assign o_vec_count = count_q;
  assign o_vec_hi    = hi_q;
  assign o_vec_lo    = lo_q;
  assign o_vec_err   = err_q;

endmodule

// File: tb/tb_index_vector_packer.sv
// Self-checking bench for index_vector_packer: table frames, hand sequences, random frames vs model.
module tb_index_vector_packer;

  localparam int WIDTH = 8;
  localparam int IW    = $clog2(WIDTH) + 1;
  localparam int MAXB  = 6;

`ifdef INDEX_VECTOR_PACKER_DUP_ERR_EN
  localparam bit DupErr = 1'b1;
`else
  localparam bit DupErr = 1'b0;
`endif

  typedef logic [IW-1:0] beats_t [MAXB];

  typedef struct {
    int               n;
    beats_t           idx;
    logic [WIDTH-1:0] vec;
    logic [IW-1:0]    cnt;
    logic [IW-1:0]    hi;
    logic [IW-1:0]    lo;
    logic             err;
  } rec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             idx_valid = 1'b0;
  logic             idx_ready;
  logic [IW-1:0]    idx = '0;
  logic             idx_last = 1'b0;
  logic             vec_valid;
  logic             vec_ready = 1'b0;
  logic [WIDTH-1:0] vec;
  logic [IW-1:0]    vec_count;
  logic [IW-1:0]    vec_hi;
  logic [IW-1:0]    vec_lo;
  logic             vec_err;

  int checks = 0;
  int errors = 0;
  rec_t tbl[$];

  index_vector_packer #(.WIDTH(WIDTH)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_idx_valid (idx_valid),
    .o_idx_ready (idx_ready),
    .i_idx       (idx),
    .i_idx_last  (idx_last),
    .o_vec_valid (vec_valid),
    .i_vec_ready (vec_ready),
    .o_vec       (vec),
    .o_vec_count (vec_count),
    .o_vec_hi    (vec_hi),
    .o_vec_lo    (vec_lo),
    .o_vec_err   (vec_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input int n, input beats_t b, input logic [WIDTH-1:0] v,
                     input logic [IW-1:0] c, input logic [IW-1:0] h, input logic [IW-1:0] l,
                     input logic e);
    rec_t r;
    r.n = n; r.idx = b; r.vec = v; r.cnt = c; r.hi = h; r.lo = l; r.err = e;
    tbl.push_back(r);
  endtask

  // Reference: the set of distinct in-range indices seen in the frame.
  task automatic model(input int n, input beats_t b, output logic [WIDTH-1:0] v,
                       output logic [IW-1:0] c, output logic [IW-1:0] h,
                       output logic [IW-1:0] l, output logic e);
    bit seen [1:WIDTH];
    int cnt, hi, lo;
    for (int k = 1; k <= WIDTH; k++) seen[k] = 1'b0;
    e = 1'b0;
    for (int i = 0; i < n; i++) begin
      int x = int'(b[i]);
      if (x > WIDTH) e = 1'b1;
      else if (x >= 1) begin
        if (seen[x]) e = e | DupErr;
        seen[x] = 1'b1;
      end
    end
    cnt = 0; hi = 0; lo = 0; v = '0;
    for (int k = 1; k <= WIDTH; k++) begin
      if (seen[k]) begin
        cnt++;
        hi = k;
        if (lo == 0) lo = k;
        v[k-1] = 1'b1;
      end
    end
    c = IW'(cnt); h = IW'(hi); l = IW'(lo);
  endtask

  // Feeds one frame; returns at the negedge one cycle after the last beat was accepted.
  task automatic send_frame(input string tag, input int n, input beats_t b);
    for (int i = 0; i < n; i++) begin
      int w = 0;
      @(negedge clk);
      idx_valid = 1'b1;
      idx       = b[i];
      idx_last  = (i == n - 1);
      while (!idx_ready && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (!idx_ready) check({tag, " ready_timeout"}, 32'(idx_ready), 32'd1);
      @(posedge clk);
    end
    @(negedge clk);
    idx_valid = 1'b0;
    idx_last  = 1'b0;
    idx       = '0;
  endtask

  task automatic check_out(input string tag, input logic [WIDTH-1:0] v, input logic [IW-1:0] c,
                           input logic [IW-1:0] h, input logic [IW-1:0] l, input logic e);
    check({tag, " valid"}, 32'(vec_valid), 32'd1);
    check({tag, " vec"},   32'(vec),       32'(v));
    check({tag, " count"}, 32'(vec_count), 32'(c));
    check({tag, " hi"},    32'(vec_hi),    32'(h));
    check({tag, " lo"},    32'(vec_lo),    32'(l));
    check({tag, " err"},   32'(vec_err),   32'(e));
  endtask

  task automatic release_frame(input string tag);
    vec_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vec_ready = 1'b0;
    check({tag, " ready_after"}, 32'(idx_ready), 32'd1);
    check({tag, " valid_after"}, 32'(vec_valid), 32'd0);
    check({tag, " vec_after"},   32'(vec),       32'd0);
  endtask

  initial begin
    beats_t b;
    logic [WIDTH-1:0] mv;
    logic [IW-1:0] mc, mh, ml;
    logic me;

    b = '{4'd3, 4'd7, 4'd1, 4'd0, 4'd0, 4'd0}; add(3, b, 8'h45, 4'd3, 4'd7, 4'd1, 1'b0);
    b = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}; add(1, b, 8'h00, 4'd0, 4'd0, 4'd0, 1'b0);
    b = '{4'd9, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0}; add(2, b, 8'h02, 4'd1, 4'd2, 4'd2, 1'b1);
    b = '{4'd4, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0}; add(2, b, 8'h08, 4'd1, 4'd4, 4'd4, DupErr);
    b = '{4'd8, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0}; add(2, b, 8'h81, 4'd2, 4'd8, 4'd1, 1'b0);
    b = '{4'd5, 4'd0, 4'd15, 4'd6, 4'd5, 4'd0}; add(5, b, 8'h30, 4'd2, 4'd6, 4'd5, 1'b1);
    b = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd7, 4'd1}; add(6, b, 8'hEB, 4'd6, 4'd8, 4'd1, 1'b0);

    // Reset state
    #12;
    check("reset valid", 32'(vec_valid), 32'd0);
    check("reset vec",   32'(vec),       32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post-reset ready", 32'(idx_ready), 32'd1);

    foreach (tbl[i]) begin
      string tag = $sformatf("tbl%0d", i);
      send_frame(tag, tbl[i].n, tbl[i].idx);
      check_out(tag, tbl[i].vec, tbl[i].cnt, tbl[i].hi, tbl[i].lo, tbl[i].err);
      release_frame(tag);
    end

    // Backpressure: outputs hold, beats offered during HOLD are ignored
    b = '{4'd3, 4'd7, 4'd1, 4'd0, 4'd0, 4'd0};
    send_frame("bp", 3, b);
    idx_valid = 1'b1; idx = 4'd2; idx_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check_out($sformatf("bp hold%0d", c), 8'h45, 4'd3, 4'd7, 4'd1, 1'b0);
      check("bp ready", 32'(idx_ready), 32'd0);
      @(negedge clk);
    end
    idx_valid = 1'b0; idx = '0; idx_last = 1'b0;
    release_frame("bp");
    b = '{4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    send_frame("bp next", 1, b);
    check_out("bp next", 8'h02, 4'd1, 4'd2, 4'd2, 1'b0);
    release_frame("bp next");

    // Asynchronous reset while a frame is held
    b = '{4'd6, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0};
    send_frame("arst", 2, b);
    check("arst pre valid", 32'(vec_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst valid", 32'(vec_valid), 32'd0);
    check("arst vec",   32'(vec),       32'd0);
    check("arst count", 32'(vec_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("arst ready", 32'(idx_ready), 32'd1);

    // Random frames against the model, with random consumer stall
    for (int f = 0; f < 60; f++) begin
      int n = int'($urandom_range(1, MAXB));
      int stall = int'($urandom_range(0, 3));
      string tag = $sformatf("rnd%0d", f);
      for (int i = 0; i < MAXB; i++) b[i] = IW'($urandom_range(0, WIDTH + 3));
      model(n, b, mv, mc, mh, ml, me);
      send_frame(tag, n, b);
      for (int s = 0; s < stall; s++) begin
        check({tag, " stall_ready"}, 32'(idx_ready), 32'd0);
        @(negedge clk);
      end
      check_out(tag, mv, mc, mh, ml, me);
      release_frame(tag);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
